// File: rtl/top_selftest_driver_if.sv
// -----------------------------------------------------------------------------
// top_selftest_driver_if
//   Signal bundle between the on-chip self-test driver and the AND datapath it
//   exercises (plus the run-control/status seen by whoever launches the test).
//
//   master : the self-test driver (consumes start/c, produces stimulus+status)
//   slave  : the environment (datapath response, run request, status reader)
//
//   start          run request
//   c              datapath response
//   a, b           datapath stimulus
//   busy           run in progress
//   done           run finished (level)
//   pass           done with zero mismatches
//   vec_count      vectors checked in current/last run
//   err_count      mismatches, saturating
//   first_err_idx  index of first mismatching vector
// -----------------------------------------------------------------------------
interface top_selftest_driver_if #(
    parameter int unsigned ERR_WIDTH = 8,
    parameter int unsigned VEC_BITS  = 7
);
    logic                 start;
    logic                 c;
    logic                 a;
    logic                 b;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [VEC_BITS-1:0]  vec_count;
    logic [ERR_WIDTH-1:0] err_count;
    logic [VEC_BITS-1:0]  first_err_idx;

    modport master (
        input  start, c,
        output a, b, busy, done, pass, vec_count, err_count, first_err_idx
    );

    modport slave (
        output start, c,
        input  a, b, busy, done, pass, vec_count, err_count, first_err_idx
    );
endinterface

// File: rtl/top_selftest_driver.sv
// -----------------------------------------------------------------------------
// top_selftest_driver
//   Synthesizable stimulus generator / response checker for the AND datapath
//   (c = a & b). Each vector takes a/b from a 16-bit Galois LFSR, lets them
//   settle SETTLE_CYCLES extra cycles, samples c, and counts vectors and
//   mismatches. done/pass report the outcome of a run.
//
// Ports
//   clk    in  system clock, all logic on posedge
//   rst_n  in  asynchronous active-low reset
//   tst    master side of top_selftest_driver_if (start, c in; a, b, busy,
//          done, pass, vec_count, err_count, first_err_idx out)
// -----------------------------------------------------------------------------
module top_selftest_driver #(
    parameter int unsigned NUM_VECTORS   = 100,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int unsigned ERR_WIDTH     = 8,
    localparam int unsigned VEC_BITS     = $clog2(NUM_VECTORS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    top_selftest_driver_if.master tst
);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // The settle counter only ever holds SETTLE_CYCLES-1 down to 0.
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD =
        SET_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

    localparam logic [VEC_BITS-1:0]  LAST_VEC = VEC_BITS'(NUM_VECTORS - 1);
    localparam logic [ERR_WIDTH-1:0] ERR_MAX  = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic                 a_q, a_d;
    logic                 b_q, b_d;
    logic [VEC_BITS-1:0]  vec_q, vec_d;
    logic [ERR_WIDTH-1:0] err_q, err_d;
    logic [VEC_BITS-1:0]  first_q, first_d;
    logic [SET_W-1:0]     settle_q, settle_d;

    logic [15:0]          lfsr_adv;
    logic                 mismatch;

    // Galois step: shift right, fold the mask in when the outgoing bit is 1.
    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_lfsr
            assign lfsr_adv[gi] = lfsr_q[gi+1] ^ (LFSR_MASK[gi] & lfsr_q[0]);
        end
    endgenerate
    assign lfsr_adv[15] = LFSR_MASK[15] & lfsr_q[0];

    assign mismatch = (tst.c != (a_q & b_q));

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        a_d      = a_q;
        b_d      = b_q;
        vec_d    = vec_q;
        err_d    = err_q;
        first_d  = first_q;
        settle_d = settle_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // a/b keep their last values; only the run bookkeeping restarts.
                if (tst.start) begin
                    lfsr_d  = SEED_EFF;
                    vec_d   = '0;
                    err_d   = '0;
                    first_d = '0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                a_d = lfsr_q[0];
                b_d = lfsr_q[1];
                if (SETTLE_CYCLES > 0) begin
                    settle_d = SETTLE_LOAD;
                    state_d  = ST_SETTLE;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    if (err_q == '0) begin
                        first_d = vec_q;
                    end
                end
                vec_d   = vec_q + 1'b1;
                lfsr_d  = lfsr_adv;
                state_d = (vec_q == LAST_VEC) ? ST_DONE : ST_DRIVE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= SEED_EFF;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            vec_q    <= '0;
            err_q    <= '0;
            first_q  <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            vec_q    <= vec_d;
            err_q    <= err_d;
            first_q  <= first_d;
            settle_q <= settle_d;
        end
    end

    assign tst.a             = a_q;
    assign tst.b             = b_q;
    assign tst.busy          = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) ||
                               (state_q == ST_CHECK);
    assign tst.done          = (state_q == ST_DONE);
    assign tst.pass          = (state_q == ST_DONE) && (err_q == '0);
    assign tst.vec_count     = vec_q;
    assign tst.err_count     = err_q;
    assign tst.first_err_idx = first_q;

endmodule

// File: tb/tb_top_selftest_driver.sv
// -----------------------------------------------------------------------------
// tb_top_selftest_driver
//   Three driver instances: defaults with a selectable datapath response,
//   ERR_WIDTH=4 against an inverting datapath, and SETTLE_CYCLES=0 /
//   NUM_VECTORS=1 against a golden datapath. Expected values come from a
//   software LFSR sequence and a per-vector error model.
// -----------------------------------------------------------------------------
module tb_top_selftest_driver;
    localparam int NV  = 100;
    localparam int S   = 1;
    localparam int PER = S + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    top_selftest_driver_if #(.ERR_WIDTH(8), .VEC_BITS(7)) if0 ();
    top_selftest_driver_if #(.ERR_WIDTH(4), .VEC_BITS(7)) if1 ();
    top_selftest_driver_if #(.ERR_WIDTH(8), .VEC_BITS(1)) if2 ();

    // Datapath response of if0: 0 golden, 1 stuck-at-0, 2 inverted, 3 random flips
    int          mode;
    logic        flip_cur;
    bit          flip_tab [NV];
    logic [15:0] lfsr_seq [NV];

    int tests_run    = 0;
    int tests_failed = 0;

    assign if0.c = (mode == 0) ? (if0.a & if0.b) :
                   (mode == 1) ? 1'b0 :
                   (mode == 2) ? ~(if0.a & if0.b) :
                                 ((if0.a & if0.b) ^ flip_cur);
    assign if1.c = ~(if1.a & if1.b);
    assign if2.c = if2.a & if2.b;

    top_selftest_driver u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .tst   (if0)
    );

    top_selftest_driver #(.ERR_WIDTH(4)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .tst   (if1)
    );

    top_selftest_driver #(.SETTLE_CYCLES(0), .NUM_VECTORS(1)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .tst   (if2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected err_count / first_err_idx for a full run of if0's datapath.
    function automatic void model(input int md, input int errmax,
                                  output int err, output int first);
        logic ab;
        logic cv;
        err   = 0;
        first = 0;
        for (int i = 0; i < NV; i++) begin
            ab = lfsr_seq[i][0] & lfsr_seq[i][1];
            case (md)
                0:       cv = ab;
                1:       cv = 1'b0;
                2:       cv = ~ab;
                default: cv = ab ^ flip_tab[i];
            endcase
            if (cv != ab) begin
                if (err == 0) first = i;
                if (err < errmax) err++;
            end
        end
    endfunction

    function automatic logic [31:0] outs0();
        return 32'({if0.a, if0.b, if0.busy, if0.done, if0.pass,
                    if0.vec_count, if0.err_count, if0.first_err_idx});
    endfunction

    // One full run on if0. reset_at >= 0 aborts with rst_n at that edge count.
    task automatic run0(input int md, input int reset_at, input bit poke);
        int n;
        int nxt;
        int done_edge;
        int exp_err;
        int exp_first;
        mode      = md;
        flip_cur  = 1'b0;
        done_edge = -1;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        @(negedge clk);
        if0.start = 1'b1;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        n = 0;
        check("start_clears", 32'({if0.busy, if0.done, if0.vec_count, if0.err_count,
                                  if0.first_err_idx}), 32'({1'b1, 1'b0, 7'd0, 8'd0, 7'd0}));
        while (n < 1000) begin
            nxt = n + 1;
            if ((nxt % PER) == 0 && (nxt / PER) - 1 < NV)
                flip_cur = flip_tab[(nxt / PER) - 1];
            if (poke && n == 37) if0.start = 1'b1;
            if (poke && n == 38) if0.start = 1'b0;
            if (reset_at >= 0 && n == reset_at) begin
                rst_n = 1'b0;
                #1;
                check("async_reset", outs0(), 32'd0);
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                check("after_reset", outs0(), 32'd0);
                $display("[TB] run mode=%0d aborted by reset at edge %0d", md, n);
                return;
            end
            @(posedge clk);
            #1;
            n = nxt;
            if (((n - 1) % PER) == 0 && ((n - 1) / PER) < NV)
                check("ab_vector", 32'({if0.a, if0.b}),
                      32'({lfsr_seq[(n-1)/PER][0], lfsr_seq[(n-1)/PER][1]}));
            if (n == 1)
                check("busy_pass", 32'({if0.busy, if0.pass}), 32'({1'b1, 1'b0}));
            if (if0.done) begin
                done_edge = n;
                break;
            end
        end
        model(md, 255, exp_err, exp_first);
        check("done_edge", 32'(done_edge), 32'(NV * PER));
        check("vec_count", 32'(if0.vec_count), 32'(NV));
        check("err_count", 32'(if0.err_count), 32'(exp_err));
        if (exp_err != 0)
            check("first_err", 32'(if0.first_err_idx), 32'(exp_first));
        check("pass", 32'(if0.pass), 32'(exp_err == 0));
        $display("[TB] run mode=%0d poke=%0d done_edge=%0d err=%0d first=%0d pass=%0d",
                 md, poke, done_edge, if0.err_count, if0.first_err_idx, if0.pass);
    endtask

    initial begin
        logic [15:0] l;
        int n;
        rst_n     = 1'b0;
        if0.start = 1'b0;
        if1.start = 1'b0;
        if2.start = 1'b0;
        mode      = 0;
        flip_cur  = 1'b0;

        l = 16'hACE1;
        for (int i = 0; i < NV; i++) begin
            lfsr_seq[i] = l;
            if (l[0]) l = (l >> 1) ^ 16'hB400;
            else      l = l >> 1;
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset_dut0", outs0(), 32'd0);
        check("reset_dut1", 32'({if1.a, if1.b, if1.busy, if1.done, if1.pass,
                                 if1.vec_count, if1.err_count, if1.first_err_idx}), 32'd0);
        check("reset_dut2", 32'({if2.a, if2.b, if2.busy, if2.done, if2.pass,
                                 if2.vec_count, if2.err_count, if2.first_err_idx}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run0(0, -1, 1'b0);           // golden
        run0(0, -1, 1'b1);           // start from DONE, start poked while busy
        run0(1, -1, 1'b0);           // stuck-at-0
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NV; i++) flip_tab[i] = ($urandom_range(0, 3) == 0);
            run0(3, -1, 1'b0);       // random response faults
        end
        run0(0, 150, 1'b0);          // abort at vector 50
        run0(0, -1, 1'b0);           // full rerun after reset

        // ERR_WIDTH=4 with an inverting datapath: saturates at 15
        @(negedge clk);
        if1.start = 1'b1;
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        n = 0;
        while (n < 1000 && !if1.done) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("sat_done_edge", 32'(n), 32'(NV * PER));
        check("sat_err", 32'(if1.err_count), 32'd15);
        check("sat_first", 32'(if1.first_err_idx), 32'd0);
        check("sat_vec", 32'(if1.vec_count), 32'(NV));
        check("sat_pass", 32'(if1.pass), 32'd0);
        $display("[TB] sat run done_edge=%0d err=%0d", n, if1.err_count);

        // SETTLE_CYCLES=0, NUM_VECTORS=1
        @(negedge clk);
        if2.start = 1'b1;
        @(posedge clk);
        #1;
        if2.start = 1'b0;
        check("s0_k_ab", 32'({if2.a, if2.b}), 32'd0);
        check("s0_k_busy_done", 32'({if2.busy, if2.done}), 32'({1'b1, 1'b0}));
        @(posedge clk);
        #1;
        check("s0_k1_ab", 32'({if2.a, if2.b}), 32'({lfsr_seq[0][0], lfsr_seq[0][1]}));
        check("s0_k1_done", 32'(if2.done), 32'd0);
        @(posedge clk);
        #1;
        check("s0_k2_done_pass", 32'({if2.done, if2.pass, if2.busy}), 32'({1'b1, 1'b1, 1'b0}));
        check("s0_k2_vec", 32'(if2.vec_count), 32'd1);
        $display("[TB] settle0 run done=%0d vec=%0d", if2.done, if2.vec_count);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
